// File: rtl/pic_host_pkg.sv
// Shared definitions for the 8259 host bus initiator and the PIC bench:
// FSM state encoding, strobe levels and the phase timer width.
package pic_host_pkg;

   localparam int unsigned CNT_W = $clog2(16);

   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_LO    = 3'd1,
      ST_RD_LO    = 3'd2,
      ST_INTA1_LO = 3'd3,
      ST_INTA_GAP = 3'd4,
      ST_INTA2_LO = 3'd5,
      ST_RECOVER  = 3'd6
   } state_t;

endpackage

// File: rtl/pic_strobe_timer.sv
// Load/count-down phase timer; done_c is high on the last clock of a phase.
module pic_strobe_timer
   import pic_host_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done_c
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count > CNT_W'(1))
         count <= count - CNT_W'(1);
   end

   assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/pic_host_bus_ctrl.sv
// CPU-side 8259 bus initiator: timed register read/write cycles and the
// two-pulse INTA acknowledge with vector capture on the second pulse.
module pic_host_bus_ctrl
   import pic_host_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = 2,
   parameter int unsigned GAP_CYCLES   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rnw,
   input  logic       cmd_a0,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   input  logic       int_req,
   output logic       vec_valid,
   input  logic       vec_ready,
   output logic [7:0] vec_data,
   output logic       chip_select_n,
   output logic       read_n,
   output logic       write_n,
   output logic       a0,
   output logic       inta_n,
   output logic [7:0] data_out,
   output logic       data_oe,
   input  logic [7:0] data_in
);

   state_t           state;
   logic             ready_q;
   logic             pulse_c;
   logic             tmr_load_c;
   logic             tmr_done_c;
   logic [CNT_W-1:0] tmr_val_c;

   // A pending acknowledge masks readiness in the same cycle so a host
   // command is never handshaken while the INTA sequence is taking the bus.
   assign cmd_ready = ready_q & (~int_req | vec_valid);

   // Reloading every IDLE cycle keeps the timer primed for whichever phase starts next.
   always_comb begin
      pulse_c    = state inside {ST_WR_LO, ST_RD_LO, ST_INTA1_LO, ST_INTA2_LO};
      tmr_load_c = (state == ST_IDLE) | tmr_done_c;
      tmr_val_c  = pulse_c ? CNT_W'(GAP_CYCLES) : CNT_W'(PULSE_CYCLES);
   end

   pic_strobe_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load_c),
      .load_val (tmr_val_c),
      .done_c   (tmr_done_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         ready_q       <= 1'b0;
         chip_select_n <= STROBE_OFF;
         read_n        <= STROBE_OFF;
         write_n       <= STROBE_OFF;
         inta_n        <= STROBE_OFF;
         a0            <= 1'b0;
         data_out      <= 8'h00;
         data_oe       <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= 8'h00;
         vec_valid     <= 1'b0;
         vec_data      <= 8'h00;
      end else begin
         rsp_valid <= 1'b0;
         if (vec_valid && vec_ready)
            vec_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (int_req && !vec_valid) begin
                  state   <= ST_INTA1_LO;
                  ready_q <= 1'b0;
                  inta_n  <= STROBE_ON;
               end else if (cmd_valid && cmd_ready) begin
                  ready_q       <= 1'b0;
                  a0            <= cmd_a0;
                  chip_select_n <= STROBE_ON;
                  if (cmd_rnw) begin
                     state  <= ST_RD_LO;
                     read_n <= STROBE_ON;
                  end else begin
                     state    <= ST_WR_LO;
                     write_n  <= STROBE_ON;
                     data_out <= cmd_data;
                     data_oe  <= 1'b1;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_WR_LO: if (tmr_done_c) begin
               state         <= ST_RECOVER;
               chip_select_n <= STROBE_OFF;
               write_n       <= STROBE_OFF;
               data_oe       <= 1'b0;
            end
            ST_RD_LO: if (tmr_done_c) begin
               state         <= ST_RECOVER;
               chip_select_n <= STROBE_OFF;
               read_n        <= STROBE_OFF;
               rsp_data      <= data_in;
               rsp_valid     <= 1'b1;
            end
            ST_INTA1_LO: if (tmr_done_c) begin
               state  <= ST_INTA_GAP;
               inta_n <= STROBE_OFF;
            end
            ST_INTA_GAP: if (tmr_done_c) begin
               state  <= ST_INTA2_LO;
               inta_n <= STROBE_ON;
            end
            ST_INTA2_LO: if (tmr_done_c) begin
               state     <= ST_RECOVER;
               inta_n    <= STROBE_OFF;
               vec_data  <= data_in;
               vec_valid <= 1'b1;
            end
            ST_RECOVER: if (tmr_done_c) begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
